// File: rtl/dma_req_sched.sv
// Round-robin scheduler sharing one DMA engine among 4 requesters; splits descriptors into
// chunks that never cross a 4 KiB CPU page. Optional watchdog: DMA_SCHED_TIMEOUT_EN.
module dma_req_sched #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned MAX_CHUNK_BYTES = 512,
  parameter int unsigned ISSUE_GAP       = 3,
  parameter int unsigned TIMEOUT_CYCLES  = 65536
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_mode,
  input  logic [NUM_REQ*64-1:0] req_cpu_addr,
  input  logic [NUM_REQ*64-1:0] req_fpga_addr,
  input  logic [NUM_REQ*32-1:0] req_len,
  output logic [NUM_REQ-1:0]    req_done,
`ifdef DMA_SCHED_TIMEOUT_EN
  output logic [NUM_REQ-1:0]    req_err,
  output logic                  dma_rst_req,
`endif
  output logic                  dma_trans_valid,
  output logic                  dma_trans_mode,
  output logic [1:0]            dma_trans_function,
  output logic [63:0]           dma_trans_cpu_region_addr,
  output logic [63:0]           dma_trans_fpga_region_addr,
  output logic [31:0]           dma_trans_transfer_len,
  input  logic                  dma_trans_finish,
  output logic                  busy
);

  localparam logic [15:0] GapLoad  = 16'(ISSUE_GAP);
  localparam logic [31:0] MaxChunk = 32'(MAX_CHUNK_BYTES);

  typedef enum logic [2:0] {StGap, StIdle, StCalc, StIssue, StWait} state_e;

  state_e              state_q, state_d;
  logic [15:0]         gap_q, gap_d;
  logic [1:0]          rr_q, rr_d;
  logic [1:0]          g_q, g_d;
  logic                mode_q, mode_d;
  logic [63:0]         cpu_q, cpu_d;
  logic [63:0]         fpga_q, fpga_d;
  logic [31:0]         rem_q, rem_d;
  logic [NUM_REQ-1:0]  ready_q, ready_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                valid_q, valid_d;
  logic                tmode_q, tmode_d;
  logic [1:0]          tfunc_q, tfunc_d;
  logic [63:0]         tcpu_q, tcpu_d;
  logic [63:0]         tfpga_q, tfpga_d;
  logic [31:0]         tlen_q, tlen_d;
  logic                busy_q, busy_d;
`ifdef DMA_SCHED_TIMEOUT_EN
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0]         to_cnt_q, to_cnt_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
  logic [1:0]          rst_hold_q, rst_hold_d;
`endif

  logic        gnt_found;
  logic [1:0]  gnt_idx;
  logic [1:0]  cand;
  logic [63:0] gnt_cpu;
  logic [63:0] gnt_fpga;
  logic [31:0] gnt_len;
  logic [31:0] page_left;
  logic [31:0] chunk;

  // Walk offsets from the far end so the lowest offset from rr_q wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_q;
    cand      = rr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = rr_q + 2'(k);
      if (req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign gnt_cpu  = req_cpu_addr[{gnt_idx, 6'd0} +: 64];
  assign gnt_fpga = req_fpga_addr[{gnt_idx, 6'd0} +: 64];
  assign gnt_len  = req_len[{gnt_idx, 5'd0} +: 32] & ~32'd3;

  always_comb begin
    page_left = 32'd4096 - {20'd0, cpu_q[11:0]};
    chunk     = rem_q;
    if ({1'b0, MaxChunk} < {1'b0, chunk}) chunk = MaxChunk;
    if ({1'b0, page_left} < {1'b0, chunk}) chunk = page_left;
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    rr_d    = rr_q;
    g_d     = g_q;
    mode_d  = mode_q;
    cpu_d   = cpu_q;
    fpga_d  = fpga_q;
    rem_d   = rem_q;
    ready_d = '0;
    done_d  = '0;
    valid_d = 1'b0;
    tmode_d = tmode_q;
    tfunc_d = tfunc_q;
    tcpu_d  = tcpu_q;
    tfpga_d = tfpga_q;
    tlen_d  = tlen_q;
`ifdef DMA_SCHED_TIMEOUT_EN
    to_cnt_d   = '0;
    err_d      = '0;
    rst_hold_d = (rst_hold_q != 2'd0) ? rst_hold_q - 2'd1 : 2'd0;
`endif
    unique case (state_q)
      StGap: begin
        if (gap_q != 16'd0) gap_d = gap_q - 16'd1;
        else state_d = (rem_q != 32'd0) ? StCalc : StIdle;
      end
      StIdle: begin
        // A zero-length grant lands back here while its ready pulse is out; finish it
        // before granting again so a still-asserted req_valid is not taken twice.
        if (ready_q != '0) begin
          done_d = ready_q;
        end else if (gnt_found) begin
          ready_d = NUM_REQ'(1) << gnt_idx;
          g_d     = gnt_idx;
          rr_d    = gnt_idx + 2'd1;
          mode_d  = req_mode[gnt_idx];
          cpu_d   = gnt_cpu;
          fpga_d  = gnt_fpga;
          rem_d   = gnt_len;
          state_d = (gnt_len != 32'd0) ? StCalc : StIdle;
        end
      end
      StCalc: begin
        tlen_d  = chunk;
        tcpu_d  = cpu_q;
        tfpga_d = fpga_q;
        tfunc_d = g_q;
        tmode_d = mode_q;
        valid_d = 1'b1;
        state_d = StIssue;
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (dma_trans_finish) begin
          cpu_d   = cpu_q + {32'd0, tlen_q};
          fpga_d  = fpga_q + {32'd0, tlen_q};
          rem_d   = rem_q - tlen_q;
          if (rem_q == tlen_q) done_d = NUM_REQ'(1) << g_q;
          gap_d   = GapLoad;
          state_d = StGap;
        end
`ifdef DMA_SCHED_TIMEOUT_EN
        else if (to_cnt_q == TimeoutLast) begin
          err_d      = NUM_REQ'(1) << g_q;
          rst_hold_d = 2'd2;
          rem_d      = '0;
          gap_d      = GapLoad;
          state_d    = StGap;
        end else begin
          to_cnt_d = to_cnt_q + 32'd1;
        end
`endif
      end
      default: state_d = StGap;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StGap;
      gap_q   <= GapLoad;
      rr_q    <= '0;
      g_q     <= '0;
      mode_q  <= 1'b0;
      cpu_q   <= '0;
      fpga_q  <= '0;
      rem_q   <= '0;
      ready_q <= '0;
      done_q  <= '0;
      valid_q <= 1'b0;
      tmode_q <= 1'b0;
      tfunc_q <= '0;
      tcpu_q  <= '0;
      tfpga_q <= '0;
      tlen_q  <= '0;
      busy_q  <= 1'b0;
`ifdef DMA_SCHED_TIMEOUT_EN
      to_cnt_q   <= '0;
      err_q      <= '0;
      rst_hold_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      mode_q  <= mode_d;
      cpu_q   <= cpu_d;
      fpga_q  <= fpga_d;
      rem_q   <= rem_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      tmode_q <= tmode_d;
      tfunc_q <= tfunc_d;
      tcpu_q  <= tcpu_d;
      tfpga_q <= tfpga_d;
      tlen_q  <= tlen_d;
      busy_q  <= busy_d;
`ifdef DMA_SCHED_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
      rst_hold_q <= rst_hold_d;
`endif
    end
  end

  assign req_ready                  = ready_q;
  assign req_done                   = done_q;
  assign dma_trans_valid            = valid_q;
  assign dma_trans_mode             = tmode_q;
  assign dma_trans_function         = tfunc_q;
  assign dma_trans_cpu_region_addr  = tcpu_q;
  assign dma_trans_fpga_region_addr = tfpga_q;
  assign dma_trans_transfer_len     = tlen_q;
  assign busy                       = busy_q;
`ifdef DMA_SCHED_TIMEOUT_EN
  assign req_err     = err_q;
  assign dma_rst_req = (rst_hold_q != 2'd0);
`endif

endmodule

// File: tb/tb_dma_req_sched.sv
// Directed testbench for dma_req_sched; the bench itself plays the DMA engine.
module tb_dma_req_sched;
  localparam int IssueGap      = 3;
  localparam int TimeoutCycles = 100;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [3:0]   req_mode;
  logic [255:0] req_cpu_addr;
  logic [255:0] req_fpga_addr;
  logic [127:0] req_len;
  logic [3:0]   req_done;
  logic         dma_trans_valid;
  logic         dma_trans_mode;
  logic [1:0]   dma_trans_function;
  logic [63:0]  dma_trans_cpu_region_addr;
  logic [63:0]  dma_trans_fpga_region_addr;
  logic [31:0]  dma_trans_transfer_len;
  logic         dma_trans_finish;
  logic         busy;
`ifdef DMA_SCHED_TIMEOUT_EN
  logic [3:0]   req_err;
  logic         dma_rst_req;
`endif

  dma_req_sched #(
    .NUM_REQ(4), .MAX_CHUNK_BYTES(512), .ISSUE_GAP(IssueGap), .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_cpu_addr(req_cpu_addr), .req_fpga_addr(req_fpga_addr), .req_len(req_len),
    .req_done(req_done),
`ifdef DMA_SCHED_TIMEOUT_EN
    .req_err(req_err), .dma_rst_req(dma_rst_req),
`endif
    .dma_trans_valid(dma_trans_valid), .dma_trans_mode(dma_trans_mode),
    .dma_trans_function(dma_trans_function),
    .dma_trans_cpu_region_addr(dma_trans_cpu_region_addr),
    .dma_trans_fpga_region_addr(dma_trans_fpga_region_addr),
    .dma_trans_transfer_len(dma_trans_transfer_len),
    .dma_trans_finish(dma_trans_finish), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  int          g_order[$], r_at[$], c_at[$], c_func[$], c_mode[$], d_idx[$], d_at[$], fin_at[$];
  logic [63:0] c_cpu[$], c_fpga[$];
  logic [31:0] c_len[$];
  int          dbl_valid;
  int          err_idx[$], err_at[$];
  int          rst_req_hi;

  task automatic clear_logs();
    g_order.delete(); r_at.delete(); c_at.delete(); c_func.delete(); c_mode.delete();
    d_idx.delete(); d_at.delete(); fin_at.delete(); c_cpu.delete(); c_fpga.delete();
    c_len.delete(); err_idx.delete(); err_at.delete();
    dbl_valid = 0;
    rst_req_hi = 0;
  endtask

  task automatic set_req(input int i, input logic m, input logic [63:0] cpu,
                         input logic [63:0] fpga, input logic [31:0] len);
    req_mode[i]               = m;
    req_cpu_addr[i*64 +: 64]  = cpu;
    req_fpga_addr[i*64 +: 64] = fpga;
    req_len[i*32 +: 32]       = len;
    req_valid[i]              = 1'b1;
  endtask

  // Engine model: logs grants, chunks and dones; answers each issue with a finish pulse
  // fin_delay cycles later unless the chunk belongs to hang_func.
  task automatic serve(input int want_done, input int stop_chunks, input int limit,
                       input int fin_delay, input int hang_func);
    int pend;
    int n;
    bit prev_v;
    pend = -1;
    n = 0;
    prev_v = 1'b0;
    while (d_idx.size() < want_done && n < limit &&
           !(stop_chunks > 0 && c_len.size() >= stop_chunks)) begin
      @(negedge clk);
      n++;
      dma_trans_finish = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i]) begin
          g_order.push_back(i);
          r_at.push_back(cyc);
          req_valid[i] = 1'b0;
        end
        if (req_done[i]) begin
          d_idx.push_back(i);
          d_at.push_back(cyc);
        end
`ifdef DMA_SCHED_TIMEOUT_EN
        if (req_err[i]) begin
          err_idx.push_back(i);
          err_at.push_back(cyc);
        end
`endif
      end
`ifdef DMA_SCHED_TIMEOUT_EN
      if (dma_rst_req) rst_req_hi++;
`endif
      if (pend == 0) begin
        dma_trans_finish = 1'b1;
        fin_at.push_back(cyc);
        pend = -1;
      end else if (pend > 0) begin
        pend--;
      end
      if (dma_trans_valid) begin
        if (prev_v) dbl_valid++;
        c_at.push_back(cyc);
        c_func.push_back(int'(dma_trans_function));
        c_mode.push_back(int'(dma_trans_mode));
        c_cpu.push_back(dma_trans_cpu_region_addr);
        c_fpga.push_back(dma_trans_fpga_region_addr);
        c_len.push_back(dma_trans_transfer_len);
        pend = (int'(dma_trans_function) == hang_func) ? -1 : fin_delay;
      end
      prev_v = dma_trans_valid;
    end
    dma_trans_finish = 1'b0;
  endtask

  task automatic test_reset();
    int got;
    rst = 1'b1;
    req_valid = '0; req_mode = '0; req_cpu_addr = '0; req_fpga_addr = '0; req_len = '0;
    dma_trans_finish = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    got = {req_ready, req_done, dma_trans_valid, dma_trans_mode, dma_trans_function, busy};
    if (got !== 0) begin
      errors++; $display("FAIL reset_ctrl: got %0h want 0", got);
    end
    checks++;
    if ({dma_trans_cpu_region_addr, dma_trans_fpga_region_addr, dma_trans_transfer_len} !== '0)
    begin
      errors++; $display("FAIL reset_fields: got %0h/%0h/%0h want 0", dma_trans_cpu_region_addr,
                         dma_trans_fpga_region_addr, dma_trans_transfer_len);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL reset_gap_busy: got %0b want 1", busy);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle_busy: got %0b want 0", busy);
    end
  endtask

  task automatic test_round_robin();
    clear_logs();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 64'h4000 + 64'(i * 64), 64'(i * 16), 32'd16);
    serve(4, 0, 300, 2, -1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ((g_order.size() > i ? g_order[i] : -1) !== i) begin
        errors++; $display("FAIL rr_grant%0d: got %0d want %0d", i,
                           (g_order.size() > i ? g_order[i] : -1), i);
      end
      checks++;
      if ((c_func.size() > i ? c_func[i] : -1) !== i) begin
        errors++; $display("FAIL rr_func%0d: got %0d want %0d", i,
                           (c_func.size() > i ? c_func[i] : -1), i);
      end
    end
    for (int k = 1; k < c_at.size() && k <= fin_at.size(); k++) begin
      checks++;
      if (c_at[k] - fin_at[k-1] <= IssueGap) begin
        errors++; $display("FAIL rr_gap%0d: got %0d cycles want >%0d", k,
                           c_at[k] - fin_at[k-1], IssueGap);
      end
    end
    checks++;
    if (d_idx.size() !== 4 || dbl_valid !== 0) begin
      errors++; $display("FAIL rr_done_count: got %0d dones %0d long valids want 4/0",
                         d_idx.size(), dbl_valid);
    end
  endtask

  task automatic test_single_read();
    clear_logs();
    set_req(0, 1'b0, 64'h1000, 64'h0, 32'd64);
    serve(1, 0, 100, 2, -1);
    checks++;
    if (c_len.size() !== 1) begin
      errors++; $display("FAIL single_chunks: got %0d want 1", c_len.size());
    end else begin
      checks++;
      if (c_len[0] !== 32'd64 || c_func[0] !== 0 || c_mode[0] !== 0) begin
        errors++; $display("FAIL single_fields: got len %0d func %0d mode %0d want 64/0/0",
                           c_len[0], c_func[0], c_mode[0]);
      end
      checks++;
      if (c_cpu[0] !== 64'h1000 || c_fpga[0] !== 64'h0) begin
        errors++; $display("FAIL single_addr: got %0h/%0h want 1000/0", c_cpu[0], c_fpga[0]);
      end
    end
    checks++;
    if ((d_idx.size() == 1 ? d_idx[0] : -1) !== 0) begin
      errors++; $display("FAIL single_done: got %0d dones want one for req 0", d_idx.size());
    end else if (fin_at.size() == 1) begin
      checks++;
      if (d_at[0] - fin_at[0] !== 1) begin
        errors++; $display("FAIL single_done_lat: got %0d want 1", d_at[0] - fin_at[0]);
      end
    end
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL single_idle_busy: got %0b want 0", busy);
    end
  endtask

  task automatic test_split();
    logic [63:0] ecpu[3];
    logic [63:0] efpga[3];
    logic [31:0] elen[3];
    ecpu = '{64'h1F00, 64'h2000, 64'h2200};
    efpga = '{64'h8000, 64'h8100, 64'h8300};
    elen = '{32'd256, 32'd512, 32'd256};
    clear_logs();
    set_req(2, 1'b1, 64'h1F00, 64'h8000, 32'd1024);
    serve(1, 0, 300, 2, -1);
    checks++;
    if (c_len.size() !== 3) begin
      errors++; $display("FAIL split_chunks: got %0d want 3", c_len.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (c_cpu[k] !== ecpu[k] || c_fpga[k] !== efpga[k] || c_len[k] !== elen[k]) begin
          errors++; $display("FAIL split_chunk%0d: got %0h/%0h/%0d want %0h/%0h/%0d", k,
                             c_cpu[k], c_fpga[k], c_len[k], ecpu[k], efpga[k], elen[k]);
        end
        checks++;
        if (c_func[k] !== 2 || c_mode[k] !== 1) begin
          errors++; $display("FAIL split_fm%0d: got %0d/%0d want 2/1", k, c_func[k], c_mode[k]);
        end
      end
      for (int k = 1; k < 3 && k <= fin_at.size(); k++) begin
        checks++;
        if (c_at[k] - fin_at[k-1] <= IssueGap) begin
          errors++; $display("FAIL split_gap%0d: got %0d want >%0d", k,
                             c_at[k] - fin_at[k-1], IssueGap);
        end
      end
    end
    checks++;
    if (d_idx.size() !== 1 || (d_idx.size() == 1 ? d_idx[0] : -1) !== 2) begin
      errors++; $display("FAIL split_done: got %0d dones want one for req 2", d_idx.size());
    end
  endtask

  task automatic test_addr_wrap();
    clear_logs();
    set_req(3, 1'b0, 64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FFC0, 32'd514);
    serve(1, 0, 200, 2, -1);
    checks++;
    if (c_len.size() !== 2) begin
      errors++; $display("FAIL wrap_chunks: got %0d want 2", c_len.size());
    end else begin
      checks++;
      if (c_cpu[0] !== 64'hFFFF_FFFF_FFFF_FF00 || c_len[0] !== 32'd256) begin
        errors++; $display("FAIL wrap_chunk0: got %0h/%0d want ffffffffffffff00/256",
                           c_cpu[0], c_len[0]);
      end
      checks++;
      if (c_cpu[1] !== 64'h0 || c_fpga[1] !== 64'hC0 || c_len[1] !== 32'd256) begin
        errors++; $display("FAIL wrap_chunk1: got %0h/%0h/%0d want 0/c0/256",
                           c_cpu[1], c_fpga[1], c_len[1]);
      end
    end
  endtask

  task automatic test_zero_len();
    int lens[2];
    int idxs[2];
    lens = '{0, 3};
    idxs = '{1, 3};
    for (int t = 0; t < 2; t++) begin
      clear_logs();
      set_req(idxs[t], 1'b0, 64'h5000, 64'h0, 32'(lens[t]));
      serve(1, 0, 50, 2, -1);
      checks++;
      if ((g_order.size() == 1 ? g_order[0] : -1) !== idxs[t]) begin
        errors++; $display("FAIL zero_grant%0d: got %0d grants want one for req %0d", t,
                           g_order.size(), idxs[t]);
      end
      checks++;
      if ((d_idx.size() == 1 ? d_idx[0] : -1) !== idxs[t] || c_len.size() !== 0) begin
        errors++; $display("FAIL zero_done%0d: got %0d dones %0d issues want 1/0", t,
                           d_idx.size(), c_len.size());
      end else if (r_at.size() == 1) begin
        checks++;
        if (d_at[0] - r_at[0] !== 1) begin
          errors++; $display("FAIL zero_lat%0d: got %0d want 1", t, d_at[0] - r_at[0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int rel;
    clear_logs();
    set_req(0, 1'b0, 64'h1F00, 64'h0, 32'd1024);
    serve(1, 2, 200, 2, -1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({dma_trans_valid, busy, req_done, req_ready, dma_trans_function} !== '0) begin
      errors++; $display("FAIL rstmid_ctrl: got v%0b b%0b d%0h r%0h f%0d want 0",
                         dma_trans_valid, busy, req_done, req_ready, dma_trans_function);
    end
    checks++;
    if ({dma_trans_cpu_region_addr, dma_trans_fpga_region_addr, dma_trans_transfer_len} !== '0)
    begin
      errors++; $display("FAIL rstmid_fields: got %0h/%0h/%0d want 0",
                         dma_trans_cpu_region_addr, dma_trans_fpga_region_addr,
                         dma_trans_transfer_len);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    clear_logs();
    set_req(3, 1'b1, 64'h3000, 64'h40, 32'd16);
    serve(1, 0, 100, 2, -1);
    checks++;
    if (c_at.size() !== 1 || (c_at.size() == 1 ? c_func[0] : -1) !== 3) begin
      errors++; $display("FAIL rstmid_next: got %0d issues want one for req 3", c_at.size());
    end else begin
      checks++;
      if (c_at[0] - rel <= IssueGap) begin
        errors++; $display("FAIL rstmid_gap: got %0d want >%0d", c_at[0] - rel, IssueGap);
      end
    end
    checks++;
    if (d_idx.size() !== 1 || (d_idx.size() == 1 ? d_idx[0] : -1) !== 3) begin
      errors++; $display("FAIL rstmid_done: got %0d dones want one for req 3", d_idx.size());
    end
  endtask

`ifdef DMA_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    clear_logs();
    set_req(0, 1'b0, 64'h6000, 64'h0, 32'd64);
    set_req(1, 1'b0, 64'h7000, 64'h0, 32'd32);
    serve(1, 0, 400, 2, 0);
    checks++;
    if ((err_idx.size() == 1 ? err_idx[0] : -1) !== 0) begin
      errors++; $display("FAIL to_err: got %0d errs want one for req 0", err_idx.size());
    end else if (c_at.size() > 0) begin
      checks++;
      if (err_at[0] - c_at[0] !== TimeoutCycles + 1) begin
        errors++; $display("FAIL to_err_lat: got %0d want %0d", err_at[0] - c_at[0],
                           TimeoutCycles + 1);
      end
    end
    checks++;
    if (rst_req_hi !== 2) begin
      errors++; $display("FAIL to_rst_req: got %0d cycles want 2", rst_req_hi);
    end
    checks++;
    if (d_idx.size() !== 1 || (d_idx.size() == 1 ? d_idx[0] : -1) !== 1) begin
      errors++; $display("FAIL to_next_done: got %0d dones want one for req 1", d_idx.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_split();
    test_addr_wrap();
    test_zero_len();
    test_reset_mid();
`ifdef DMA_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_req_sched.md
Name: dma_req_sched

Overview:
- Round-robin scheduler placed in front of the single simple DMA engine; shares that engine among 4 requesters (one per PCIe function).
- Each requester hands over a descriptor: mode, CPU address, FPGA address, length.
- The scheduler splits each descriptor into engine-sized chunks that never cross a 4 KiB CPU page.
- It drives the engine's dma_trans_* inputs and pulses a per-requester done once the last chunk finishes.

Parameters:
- NUM_REQ, 4, requester count; fixed at 4 because the engine function index is 2 bits.
- MAX_CHUNK_BYTES, 512, largest chunk issued to the engine; power of 2, at least 16, at most 4096.
- ISSUE_GAP, 3, minimum cycles from a dma_trans_finish pulse, or from reset release, to the next dma_trans_valid.
- TIMEOUT_CYCLES, 65536, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  4  descriptor offered, one bit per requester
- req_ready  out  4  descriptor accepted (one-cycle pulse)
- req_mode  in  4  per-requester mode: 1 = write to CPU (RQ write), 0 = read from CPU
- req_cpu_addr  in  4x64  packed CPU byte address, requester i at [64i+63:64i]
- req_fpga_addr  in  4x64  packed FPGA buffer byte address
- req_len  in  4x32  packed byte length; bits [1:0] ignored
- req_done  out  4  one-cycle pulse when the whole descriptor has completed
- dma_trans_valid  out  1  start pulse to the engine
- dma_trans_mode  out  1  mode of the current chunk
- dma_trans_function  out  2  granted requester index
- dma_trans_cpu_region_addr  out  64  chunk CPU address
- dma_trans_fpga_region_addr  out  64  chunk FPGA address
- dma_trans_transfer_len  out  32  chunk byte length
- dma_trans_finish  in  1  engine completion pulse
- busy  out  1  high in every state except S_IDLE

Behaviour:
- Reset values: all outputs 0, rr pointer 0, state S_GAP with the gap counter loaded to ISSUE_GAP.
- S_GAP:
  - Counts down to 0, then goes to S_CALC if a descriptor has bytes remaining, otherwise to S_IDLE.
  - dma_trans_finish arriving here is ignored.
- S_IDLE:
  - Grants the lowest index at or after the rr pointer with req_valid=1.
  - The grant is registered: req_ready[g] pulses for exactly one cycle.
  - On the same edge the scheduler latches mode, addresses and len with bits [1:0] cleared, and advances rr to g+1 mod 4.
  - If the latched len is 0: req_done[g] pulses on the next cycle, no engine issue, return to S_IDLE.
  - Otherwise go to S_CALC.
- S_CALC (1 cycle):
  - chunk = min(remain, MAX_CHUNK_BYTES, 4096 - cpu_addr[11:0]).
  - The comparison is done in 33-bit arithmetic.
  - The result is registered onto dma_trans_transfer_len.
  - Both addresses and the function index are registered onto the dma_trans_* outputs; go to S_ISSUE.
- S_ISSUE: dma_trans_valid=1 for exactly one cycle; go to S_WAIT.
- S_WAIT:
  - All dma_trans_* fields are held stable until dma_trans_finish.
  - On finish: cpu_addr += chunk, fpga_addr += chunk, remain -= chunk.
  - If remain becomes 0, req_done[g] pulses on the next cycle.
  - Load the gap counter and go to S_GAP.
- dma_trans_valid is never high outside S_ISSUE, and never within ISSUE_GAP cycles of a finish.
- New req_valid assertions during an active descriptor are not granted until S_IDLE.
- Fairness: with all 4 requesting continuously, grant order is 0,1,2,3,0...
- Address arithmetic is 64-bit and wraps modulo 2^64 with no error.
- Asynchronous reset mid-transfer: return to the reset values at once, drop the descriptor, no req_done.

Optional Feature:
- Macro DMA_SCHED_TIMEOUT_EN.
- With the macro:
  - A counter runs in S_WAIT.
  - If it reaches TIMEOUT_CYCLES without a finish, the scheduler pulses extra outputs req_err[g] (1 cycle) and dma_rst_req (held 2 cycles, for the engine's synchronous reset).
  - The rest of the descriptor is dropped with no req_done; go to S_GAP.
- Without the macro: req_err and dma_rst_req are absent, and S_WAIT waits indefinitely.

Test Plan:
- Single read: req 0 with cpu=0x1000, fpga=0x0, len=64 -> one issue (len=64, function=0, mode=0); req_done[0] exactly 1 cycle after finish.
- Split: req 2 with cpu=0x1F00, len=1024, MAX_CHUNK=512 -> chunks 256@0x1F00, 512@0x2000, 256@0x2200; FPGA address advances to match; one req_done[2].
- Round-robin: requesters 0-3 all valid with len=16 each -> grants 0,1,2,3 in order; no valid within 3 cycles of any finish.
- Zero length: req 1 with len=0 (or len=3) -> req_ready then req_done[1], dma_trans_valid never asserts.
- Reset mid-S_WAIT: assert rst during chunk 2 -> all outputs 0 immediately; after release, first valid no earlier than 3 cycles.
- Timeout (feature on, TIMEOUT_CYCLES=100): finish withheld -> req_err[g] at cycle 100, dma_rst_req high for 2 cycles, next requester then served.
